// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin one-hot grant, registered
// broadcast of the granted unit's result one cycle after its grant.
module cdb_arbiter #(
  parameter int N_UNITS = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_UNITS-1:0]         CDB_rts,
  input  logic [N_UNITS*DATA_W-1:0]  unit_data,
  input  logic [N_UNITS*TAG_W-1:0]   unit_source,
  output logic [N_UNITS-1:0]         CDB_xmit,
  output logic [DATA_W-1:0]          CDB_data,
  output logic [TAG_W-1:0]           CDB_source,
  output logic                       CDB_write,
  output logic                       error
);

  localparam int PW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic [N_UNITS-1:0] xmit_q, xmit_d;
  logic [N_UNITS-1:0] elig;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [TAG_W-1:0]   src_q, src_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
  logic               found;
  int                 idx;

  // The unit holding the bus this cycle may not win the next one.
  always_comb begin
    elig   = CDB_rts & ~xmit_q;
    xmit_d = '0;
    ptr_d  = ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= N_UNITS; off++) begin
      idx = (int'(ptr_q) + off) % N_UNITS;
      if (!found && elig[idx]) begin
        found       = 1'b1;
        xmit_d[idx] = 1'b1;
        ptr_d       = PW'(idx);
      end
    end
  end

  always_comb begin
    wr_d   = |xmit_q;
    data_d = data_q;
    src_d  = src_q;
    for (int i = 0; i < N_UNITS; i++) begin
      if (xmit_q[i]) begin
        data_d = unit_data[i*DATA_W +: DATA_W];
        src_d  = unit_source[i*TAG_W +: TAG_W];
      end
    end
    err_d = err_q | (|(xmit_q & ~CDB_rts));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xmit_q <= '0;
      ptr_q  <= PW'(N_UNITS - 1);
      data_q <= '0;
      src_q  <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      xmit_q <= xmit_d;
      ptr_q  <= ptr_d;
      data_q <= data_d;
      src_q  <= src_d;
      wr_q   <= wr_d;
      err_q  <= err_d;
    end
  end

  assign CDB_xmit   = xmit_q;
  assign CDB_data   = data_q;
  assign CDB_source = src_q;
  assign CDB_write  = wr_q;
  assign error      = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors push expected
// grants/broadcasts, a monitor pops and compares.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 6;

  logic          clock;
  logic          reset_n;
  logic [N-1:0]  CDB_rts;
  logic [N*DW-1:0] unit_data;
  logic [N*TW-1:0] unit_source;
  logic [N-1:0]  CDB_xmit;
  logic [DW-1:0] CDB_data;
  logic [TW-1:0] CDB_source;
  logic          CDB_write;
  logic          error;

  int checks;
  int failures;

  logic [N-1:0]     gq[$];
  logic [DW+TW-1:0] bq[$];

  cdb_arbiter #(.N_UNITS(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .CDB_rts(CDB_rts),
    .unit_data(unit_data),
    .unit_source(unit_source),
    .CDB_xmit(CDB_xmit),
    .CDB_data(CDB_data),
    .CDB_source(CDB_source),
    .CDB_write(CDB_write),
    .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic set_unit(input int i, input logic [DW-1:0] d,
                          input logic [TW-1:0] s);
    unit_data[i*DW +: DW]   = d;
    unit_source[i*TW +: TW] = s;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    CDB_rts = '0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_xmit", 64'(CDB_xmit), 64'd0);
    chk("rst_write", 64'(CDB_write), 64'd0);
    chk("rst_data", 64'(CDB_data), 64'd0);
    chk("rst_src", 64'(CDB_source), 64'd0);
    chk("rst_err", 64'(error), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: compares every grant and broadcast against the queues.
  always @(posedge clock) begin
    #2;
    if (reset_n) begin
      if (CDB_xmit != '0) begin
        if (gq.size() == 0)
          chk("grant_unexpected", 64'(CDB_xmit), 64'd0);
        else
          chk("grant", 64'(CDB_xmit), 64'(gq.pop_front()));
      end
      if (CDB_write) begin
        if (bq.size() == 0)
          chk("bcast_unexpected", 64'({CDB_data, CDB_source}), 64'd0);
        else
          chk("bcast", 64'({CDB_data, CDB_source}),
              64'(bq.pop_front()));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b1;
    CDB_rts     = '0;
    unit_data   = '0;
    unit_source = '0;
    #1;
    do_reset();

    // Single request from unit 1
    set_unit(1, 32'd10, 6'd2);
    CDB_rts = 4'b0010;
    gq.push_back(4'b0010);
    bq.push_back({32'd10, 6'd2});
    tick();
    chk("single_grant", 64'(CDB_xmit), 64'b0010);
    tick();
    chk("single_write", 64'(CDB_write), 64'd1);
    chk("single_nogrant", 64'(CDB_xmit), 64'd0);
    CDB_rts = '0;
    repeat (3) tick();
    chk("single_idle", 64'({CDB_xmit, CDB_write}), 64'd0);
    chk("single_err", 64'(error), 64'd0);

    // Round-robin with all units requesting
    do_reset();
    for (int i = 0; i < N; i++)
      set_unit(i, 32'(i * 11 + 5), 6'(i + 8));
    set_unit(2, -32'sd7, 6'd10);
    CDB_rts = 4'b1111;
    gq.push_back(4'b0001); gq.push_back(4'b0010);
    gq.push_back(4'b0100); gq.push_back(4'b1000);
    gq.push_back(4'b0001);
    bq.push_back({32'd5, 6'd8});
    bq.push_back({32'd16, 6'd9});
    bq.push_back({32'hFFFF_FFF9, 6'd10});
    bq.push_back({32'd38, 6'd11});
    bq.push_back({32'd5, 6'd8});
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_write", 64'(CDB_write), 64'd1);
    end
    CDB_rts = 4'b0001;
    tick();
    chk("rr_last_write", 64'(CDB_write), 64'd1);
    chk("rr_last_nogrant", 64'(CDB_xmit), 64'd0);
    CDB_rts = '0;
    tick();
    chk("rr_err", 64'(error), 64'd0);

    // Same-unit exclusion, data changing every cycle
    do_reset();
    set_unit(2, 32'd200, 6'd33);
    CDB_rts = 4'b0100;
    gq.push_back(4'b0100); gq.push_back(4'b0100);
    gq.push_back(4'b0100);
    bq.push_back({32'd201, 6'd33});
    bq.push_back({32'd203, 6'd33});
    bq.push_back({32'd205, 6'd33});
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("excl_xmit2", 64'(CDB_xmit[2]), 64'(k % 2));
      chk("excl_write", 64'(CDB_write), 64'((k + 1) % 2));
      set_unit(2, 32'(200 + k), 6'd33);
    end
    CDB_rts = '0;
    repeat (2) tick();

    // Wrap: last grant unit 3, then 0, then 3
    do_reset();
    set_unit(0, 32'h1234_5678, 6'd1);
    set_unit(3, 32'h8000_0000, 6'd63);
    CDB_rts = 4'b1000;
    gq.push_back(4'b1000); gq.push_back(4'b0001);
    gq.push_back(4'b1000);
    bq.push_back({32'h8000_0000, 6'd63});
    bq.push_back({32'h1234_5678, 6'd1});
    bq.push_back({32'h8000_0000, 6'd63});
    tick();
    chk("wrap_g3", 64'(CDB_xmit), 64'b1000);
    CDB_rts = 4'b1001;
    tick();
    chk("wrap_g0", 64'(CDB_xmit), 64'b0001);
    tick();
    chk("wrap_g3b", 64'(CDB_xmit), 64'b1000);
    CDB_rts = 4'b1000;
    tick();
    CDB_rts = '0;
    repeat (2) tick();
    chk("wrap_err", 64'(error), 64'd0);

    // Protocol violation: unit 0 withdraws while granted
    do_reset();
    set_unit(0, 32'd77, 6'd5);
    CDB_rts = 4'b0001;
    gq.push_back(4'b0001);
    bq.push_back({32'd77, 6'd5});
    tick();
    chk("viol_grant", 64'(CDB_xmit), 64'b0001);
    chk("viol_err_pre", 64'(error), 64'd0);
    CDB_rts = '0;
    tick();
    chk("viol_err", 64'(error), 64'd1);
    chk("viol_write", 64'(CDB_write), 64'd1);
    repeat (3) tick();
    chk("viol_sticky", 64'(error), 64'd1);

    // Reset mid-operation discards the pending capture
    do_reset();
    set_unit(2, 32'd999, 6'd7);
    CDB_rts = 4'b0100;
    gq.push_back(4'b0100);
    tick();
    chk("mid_grant", 64'(CDB_xmit), 64'b0100);
    #2;
    reset_n = 1'b0;
    CDB_rts = '0;
    #1;
    chk("mid_rst_out", 64'({CDB_xmit, CDB_write, CDB_data,
        CDB_source, error}), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("mid_no_write", 64'(CDB_write), 64'd0);

    chk("gq_empty", 64'(gq.size()), 64'd0);
    chk("bq_empty", 64'(bq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
